// File: rtl/droute_sched.sv
// Command scheduler for the data_route fabric: holds three switch words until each switch
// reports its beat count, then idles the fabric and emits status. Optional stall timeout: DROUTE_SCHED_TIMEOUT_EN.
module droute_sched #(
  parameter int SW_W    = 19,
  parameter int ID_W    = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3*SW_W-1:0] s_cmd_tdata,
  input  logic              s_cmd_tvalid,
  output logic              s_cmd_tready,
  output logic [SW_W-1:0]   s_droute_switch_0,
  output logic [SW_W-1:0]   s_droute_switch_1,
  output logic [SW_W-1:0]   s_droute_switch_2,
  input  logic              count_switch_0_tvalid,
  input  logic              count_switch_1_tvalid,
  input  logic              count_switch_2_tvalid,
  output logic              m_done_tvalid,
  output logic [15:0]       m_done_tdata,
  input  logic              m_done_tready,
  output logic              busy,
  output logic              err_stray
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     target  [3];
  logic [15:0]     cnt     [3];
  logic [15:0]     cnt_nxt [3];
  logic [2:0]      pulse, done_now, done_nxt;
  logic [ID_W-1:0] cmd_id;
  logic            accept, stray, timeout_hit;

  assign pulse  = {count_switch_2_tvalid, count_switch_1_tvalid, count_switch_0_tvalid};
  assign accept = (state == IDLE) && s_cmd_tvalid && s_cmd_tready;

  // Counters saturate at their target; a pulse that finds the counter already there is stray.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      done_now[k] = (cnt[k] == target[k]);
      cnt_nxt[k]  = cnt[k] + {15'd0, (state == RUN) && pulse[k] && !done_now[k]};
      done_nxt[k] = (cnt_nxt[k] == target[k]);
    end
  end

  assign stray = (state != RUN) ? (|pulse) : (|(pulse & done_now));

`ifdef DROUTE_SCHED_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall;

  assign timeout_hit = (state == RUN) && (pulse == 3'b000) && (stall == ST_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                     stall <= '0;
    else if (accept || |pulse)      stall <= '0;
    else if (state == RUN)          stall <= stall + ST_W'(1);
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if ((&done_nxt) || timeout_hit) state_nxt = DONE;
      DONE:    if (m_done_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the per-switch counter/target arrays are only three entries, so they are reset
  // explicitly like ordinary registers; a reset mid-RUN must leave no stale progress behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_cmd_tready      <= 1'b0;
      s_droute_switch_0 <= '0;
      s_droute_switch_1 <= '0;
      s_droute_switch_2 <= '0;
      m_done_tvalid     <= 1'b0;
      m_done_tdata      <= '0;
      busy              <= 1'b0;
      err_stray         <= 1'b0;
      cmd_id            <= '0;
      for (int k = 0; k < 3; k++) begin
        target[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      s_cmd_tready <= (state_nxt == IDLE);
      busy         <= (state_nxt != IDLE);
      err_stray    <= err_stray | stray;
      unique case (state)
        IDLE: begin
          if (accept) begin
            s_droute_switch_0 <= s_cmd_tdata[0*SW_W +: SW_W];
            s_droute_switch_1 <= s_cmd_tdata[1*SW_W +: SW_W];
            s_droute_switch_2 <= s_cmd_tdata[2*SW_W +: SW_W];
            for (int k = 0; k < 3; k++) begin
              target[k] <= s_cmd_tdata[k*SW_W +: 16];
              cnt[k]    <= '0;
            end
          end
        end
        RUN: begin
          for (int k = 0; k < 3; k++) cnt[k] <= cnt_nxt[k];
          if (state_nxt == DONE) begin
            s_droute_switch_0 <= '0;
            s_droute_switch_1 <= '0;
            s_droute_switch_2 <= '0;
            m_done_tvalid     <= 1'b1;
            m_done_tdata      <= {timeout_hit, done_nxt, cmd_id};
          end
        end
        DONE: begin
          if (m_done_tready) begin
            m_done_tvalid <= 1'b0;
            cmd_id        <= cmd_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_droute_sched.sv
// Directed self-checking bench for droute_sched: completion timing, zero targets,
// status backpressure, stray pulses, mid-run reset and (when enabled) the stall timeout.
module tb_droute_sched;

  localparam int SW_W = 19;
`ifdef DROUTE_SCHED_TIMEOUT_EN
  localparam int TB_TIMEOUT = 64;
`else
  localparam int TB_TIMEOUT = 4096;
`endif

  logic              clk;
  logic              rst_n;
  logic [3*SW_W-1:0] s_cmd_tdata;
  logic              s_cmd_tvalid;
  logic              s_cmd_tready;
  logic [SW_W-1:0]   sw0, sw1, sw2;
  logic              p0, p1, p2;
  logic              m_done_tvalid;
  logic [15:0]       m_done_tdata;
  logic              m_done_tready;
  logic              busy;
  logic              err_stray;
  logic [3*SW_W-1:0] words;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_id   = 12'd0;

  assign words = {sw2, sw1, sw0};

  droute_sched #(.SW_W(SW_W), .ID_W(12), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .s_cmd_tdata           (s_cmd_tdata),
    .s_cmd_tvalid          (s_cmd_tvalid),
    .s_cmd_tready          (s_cmd_tready),
    .s_droute_switch_0     (sw0),
    .s_droute_switch_1     (sw1),
    .s_droute_switch_2     (sw2),
    .count_switch_0_tvalid (p0),
    .count_switch_1_tvalid (p1),
    .count_switch_2_tvalid (p2),
    .m_done_tvalid         (m_done_tvalid),
    .m_done_tdata          (m_done_tdata),
    .m_done_tready         (m_done_tready),
    .busy                  (busy),
    .err_stray             (err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3*SW_W-1:0] cmd);
    int t;
    t = 0;
    while (!s_cmd_tready && t < 10) begin
      tick();
      t++;
    end
    n_checks++;
    if (s_cmd_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_wait: s_cmd_tready=%b required 1", s_cmd_tready);
    end
    s_cmd_tdata  = cmd;
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
    s_cmd_tdata  = '0;
  endtask

  task automatic finish_status(input logic [15:0] exp);
    n_checks++;
    if (m_done_tvalid !== 1'b1 || m_done_tdata !== exp) begin
      n_fail++;
      $display("FAIL status: tvalid=%b tdata=%h required 1/%h", m_done_tvalid, m_done_tdata, exp);
    end
    m_done_tready = 1'b1;
    tick();
    m_done_tready = 1'b0;
    n_checks++;
    if ({m_done_tvalid, s_cmd_tready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL status_handshake: tvalid/tready/busy=%b required 010",
               {m_done_tvalid, s_cmd_tready, busy});
    end
    exp_id = exp_id + 12'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_cmd_tvalid = 1'b0; s_cmd_tdata = '0; m_done_tready = 1'b0;
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    tick(); tick();
    n_checks++;
    if ({s_cmd_tready, m_done_tvalid, busy, err_stray} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: tready/tvalid/busy/err=%b required 0000",
               {s_cmd_tready, m_done_tvalid, busy, err_stray});
    end
    n_checks++;
    if (words !== '0 || m_done_tdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: words=%h tdata=%h required 0/0", words, m_done_tdata);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (s_cmd_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: s_cmd_tready=%b required 1", s_cmd_tready);
    end
    exp_id = 12'd0;
  endtask

  task automatic test_basic();
    logic [3*SW_W-1:0] cmd;
    int held_bad;
    cmd = {19'h10083, 19'h2013a, 19'h100c1};
    send_cmd(cmd);
    n_checks++;
    if (words !== cmd || busy !== 1'b1 || s_cmd_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: words=%h busy=%b tready=%b required %h/1/0",
               words, busy, s_cmd_tready, cmd);
    end
    held_bad = 0;
    for (int i = 0; i < 314; i++) begin
      p0 = (i < 193); p1 = 1'b1; p2 = (i < 131);
      tick();
      if (i < 313 && (words !== cmd || m_done_tvalid !== 1'b0)) held_bad++;
    end
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    n_checks++;
    if (held_bad !== 0) begin
      n_fail++;
      $display("FAIL basic_hold: %0d early-release cycles required 0", held_bad);
    end
    n_checks++;
    if (words !== '0 || err_stray !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: words=%h err=%b required 0/0", words, err_stray);
    end
    finish_status({4'h7, exp_id});
  endtask

  task automatic test_zero_target();
    logic [3*SW_W-1:0] cmd;
    cmd = {19'h30000, 19'h20000, 19'h10000};
    send_cmd(cmd);
    n_checks++;
    if (words !== cmd) begin
      n_fail++;
      $display("FAIL zero_visible: words=%h required %h", words, cmd);
    end
    tick();
    n_checks++;
    if (words !== '0) begin
      n_fail++;
      $display("FAIL zero_one_cycle: words=%h required 0", words);
    end
    finish_status({4'h7, exp_id});
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    exp = {4'h7, exp_id};
    send_cmd({19'h00000, 19'h00000, 19'h00001});
    p0 = 1'b1;
    tick();
    p0 = 1'b0;
    s_cmd_tvalid = 1'b1;
    s_cmd_tdata  = {19'h10001, 19'h10001, 19'h10001};
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({m_done_tvalid, m_done_tdata, s_cmd_tready, words} !== {1'b1, exp, 1'b0, 57'd0}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: tvalid=%b tdata=%h tready=%b words=%h required 1/%h/0/0",
                 i, m_done_tvalid, m_done_tdata, s_cmd_tready, words, exp);
      end
    end
    s_cmd_tvalid = 1'b0;
    s_cmd_tdata  = '0;
    finish_status(exp);
  endtask

  task automatic test_stray_run();
    send_cmd({19'h00000, 19'h00002, 19'h10005});
    for (int i = 0; i < 6; i++) begin
      p0 = 1'b1;
      tick();
      if (i == 4) begin
        n_checks++;
        if (err_stray !== 1'b0) begin
          n_fail++;
          $display("FAIL stray_early: err_stray=%b required 0", err_stray);
        end
      end
    end
    p0 = 1'b0;
    n_checks++;
    if (err_stray !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_beyond: err_stray=%b required 1", err_stray);
    end
    p1 = 1'b1;
    tick();
    n_checks++;
    if (m_done_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_partial: tvalid=%b required 0", m_done_tvalid);
    end
    tick();
    p1 = 1'b0;
    // Completion here means switch 0 stayed saturated at 5 despite the sixth pulse.
    finish_status({4'h7, exp_id});
    n_checks++;
    if (err_stray !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_sticky: err_stray=%b required 1", err_stray);
    end
  endtask

  task automatic test_reset_midrun();
    send_cmd({19'h10083, 19'h2013a, 19'h100c1});
    for (int i = 0; i < 10; i++) begin
      p0 = 1'b1;
      tick();
    end
    p0 = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({words, s_cmd_tready, m_done_tvalid, m_done_tdata, busy, err_stray} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: words=%h tready=%b tvalid=%b tdata=%h busy=%b err=%b required all 0",
               words, s_cmd_tready, m_done_tvalid, m_done_tdata, busy, err_stray);
    end
    rst_n = 1'b1;
    exp_id = 12'd0;
    tick();
    n_checks++;
    if ({s_cmd_tready, m_done_tvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrun_no_status: tready/tvalid=%b required 10", {s_cmd_tready, m_done_tvalid});
    end
    test_zero_target();
  endtask

  task automatic test_stray_idle();
    p2 = 1'b1;
    tick();
    p2 = 1'b0;
    n_checks++;
    if (err_stray !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_idle: err_stray=%b required 1", err_stray);
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (err_stray !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle_hold: err=%b busy=%b required 1/0", err_stray, busy);
    end
  endtask

`ifdef DROUTE_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    send_cmd({19'h00000, 19'h00000, 19'h100c1});
    for (int i = 0; i < 100; i++) begin
      p0 = 1'b1;
      tick();
    end
    p0 = 1'b0;
    cyc = 0;
    while (!m_done_tvalid && cyc < 200) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 64) begin
      n_fail++;
      $display("FAIL timeout_delay: %0d idle cycles required 64", cyc);
    end
    n_checks++;
    if (words !== '0) begin
      n_fail++;
      $display("FAIL timeout_words: words=%h required 0", words);
    end
    finish_status({1'b1, 3'b110, exp_id});
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_target();
    test_backpressure();
    test_stray_run();
    test_reset_midrun();
    test_stray_idle();
`ifdef DROUTE_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/droute_sched.md
Name: droute_sched

Overview:
- Command-driven scheduler that sequences the data_route switch fabric.
- Accepts one command per routing phase; each command carries the three 19-bit switch words for s_droute_switch_0/1/2.
- Holds those words on the fabric until each switch reports its programmed beat count through count_switch_N_tvalid.
- Then returns the fabric to idle (all-zero words) and emits a completion status. Sits between the host/DMA command queue and data_route.

Parameters:
- SW_W, 19, width of each switch word; [18:16] route select, [15:0] beat count.
- ID_W, 12, width of command sequence counter.
- TIMEOUT, 4096, RUN-state stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- s_cmd_tdata  in  3*SW_W  {sw2, sw1, sw0}.
- s_cmd_tvalid  in  1  command valid.
- s_cmd_tready  out  1  command ready.
- s_droute_switch_0  out  SW_W  switch 0 word to data_route.
- s_droute_switch_1  out  SW_W  switch 1 word to data_route.
- s_droute_switch_2  out  SW_W  switch 2 word to data_route.
- count_switch_0_tvalid  in  1  one-cycle pulse per beat passed by switch 0.
- count_switch_1_tvalid  in  1  one-cycle pulse per beat passed by switch 1.
- count_switch_2_tvalid  in  1  one-cycle pulse per beat passed by switch 2.
- m_done_tvalid  out  1  status valid.
- m_done_tdata  out  16  {timeout, done_mask[2:0], cmd_id[ID_W-1:0]}.
- m_done_tready  in  1  status ready.
- busy  out  1  high in RUN or DONE.
- err_stray  out  1  sticky; a count pulse arrived outside RUN or beyond target.

Behaviour:
- Reset values: s_droute_switch_0/1/2 = 0, s_cmd_tready = 0, m_done_tvalid = 0, m_done_tdata = 0, busy = 0, err_stray = 0. Counters, cmd_id and state (IDLE) cleared. Reset mid-RUN zeroes the switch words on the same edge and discards the command with no status.
- FSM states: IDLE, RUN, DONE. All outputs registered.
- IDLE:
  - s_cmd_tready = 1; switch words = 0.
  - On s_cmd_tvalid & s_cmd_tready at edge N: latch the three words, set target_k = word_k[15:0], clear cnt_k, go to RUN.
  - Switch words equal the latched words from cycle N+1.
- RUN:
  - s_cmd_tready = 0; busy = 1.
  - Each count_switch_k_tvalid sampled high increments cnt_k, saturating at target_k.
  - A pulse arriving when cnt_k == target_k sets err_stray and is not counted.
  - done_k = (cnt_k == target_k); target 0 means done immediately.
  - At the edge where all done_k are true, including pulses sampled that edge, go to DONE and zero the switch words on that same edge.
  - Minimum RUN duration is 1 cycle. A command with all three targets 0 gives words visible for exactly 1 cycle.
- Simultaneous pulses on several switches in one cycle are all counted.
- DONE:
  - Switch words = 0; m_done_tvalid = 1; m_done_tdata = {1'b0, 3'b111, cmd_id}.
  - Status holds stable until m_done_tready.
  - On the handshake: cmd_id increments (wraps at 2^ID_W), go to IDLE. The next command is accepted no earlier than the following cycle, so there is at least one all-zero cycle between commands.
- Pulses in IDLE or DONE: ignored for counting; set err_stray.
- err_stray clears only on reset.

Optional Feature:
- Macro DROUTE_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter clears on command accept and on any count pulse, and increments every RUN cycle.
  - On reaching TIMEOUT it forces DONE with timeout bit = 1 and done_mask = the actual done_k values, and zeroes the switch words.
- Undefined: no stall counter; timeout bit is tied 0; RUN waits indefinitely.

Test Plan:
- Reset then command {19'h10083, 19'h2013a, 19'h100c1}; pulse switch0 193x, switch1 314x, switch2 131x -> words held until the last pulse, zero on that edge; status 16'h7000.
- Command with all targets 0 -> words nonzero for exactly 1 cycle; status 16'h7000. A second command gives cmd_id = 1 and status 16'h7001.
- Hold m_done_tready = 0 for 20 cycles in DONE -> m_done_tvalid stays 1 with stable data, s_cmd_tready = 0, switch words 0.
- Pulse switch0 once beyond a target of 5, and once while in IDLE -> err_stray = 1 and stays 1; cnt0 stays at 5.
- Assert rst_n = 0 mid-RUN after 10 of 193 pulses -> next edge all outputs at reset values; no status emitted; the next command starts with cmd_id = 0.
- With DROUTE_SCHED_TIMEOUT_EN and TIMEOUT = 64: command 19'h100c1 on switch0, pulses stop after 100 -> DONE after 64 idle cycles; status {1, 3'b110, id}.
